serial_cmd_rx: RTL and testbench
================================

# serial_cmd_rx

Parametrised SUMP command front-end: oversampling UART receiver plus command assembler that turns the host byte stream into 40-bit commands (`{opdata, opcode}`) with a one-cycle `execute` strobe. It also decodes the query opcodes and the reset opcode into strobes. Beyond the existing receive path it adds:
- runtime baud-divisor reload;
- an inter-byte timeout;
- framing-error and overrun reporting;
- a `hold` input that defers delivery while the transmitter is busy.

It sits between the `rx` pin and the core decoder / serial transmitter.

## Interface
Parameters:
- `FREQ`, 100000000, system clock frequency in Hz.
- `RATE`, 115200, default baud rate.
- `OVERSAMPLE`, 16, ticks per bit; even, ≥4.
- `TIMEOUT_BITS`, 32, inter-byte timeout in bit-times; 0 disables the timeout.
- `DIV_W`, 16, baud divisor width.

Ports:
- `clock`  in  1  sole clock.
- `extReset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; synchronised internally by 2 flops.
- `baud_div`  in  DIV_W  new divisor value: clocks per tick, minus 1.
- `baud_div_load`  in  1  one-cycle load strobe for `baud_div`.
- `hold`  in  1  high = do not deliver a completed command.
- `cmd`  out  40  `{opdata[31:0], opcode[7:0]}`; valid while `execute` is high, stable until the next delivery.
- `execute`  out  1  one-cycle command strobe.
- `query_id`, `query_metadata`, `query_dataIn`, `query_reset`  out  1 each  one-cycle strobes, coincident with `execute`, for opcodes 0x02, 0x04, 0x06 and 0x00.
- `framing_err`  out  1  one-cycle pulse.
- `overrun`  out  1  one-cycle pulse.
- `timeout`  out  1  one-cycle pulse.

## Operation
Reset:
- All outputs reset to 0.
- Divisor register resets to `DEFAULT_DIV = FREQ/(RATE*OVERSAMPLE) - 1`, integer division.
- Both FSMs reset to IDLE/WAIT_OP.

Tick generator:
- Down-counter reloaded from the divisor register; emits one tick every `div+1` clocks.
- `baud_div_load`: divisor register takes `baud_div` next cycle. The tick counter is cleared, the byte FSM returns to IDLE and any partial byte is dropped.
- The assembler is not affected by `baud_div_load`.

Byte FSM (IDLE → START → DATA → STOP → IDLE):
- IDLE: a low synchronised `rx` on a tick enters START.
- START: at `OVERSAMPLE/2` ticks, `rx` still low → DATA; `rx` high → IDLE (glitch, no error reported).
- DATA: 8 samples, each `OVERSAMPLE` ticks apart, LSB first.
- STOP: sampled `OVERSAMPLE` ticks after the last data bit.
  - Stop bit = 1: `byte_valid` for one cycle.
  - Stop bit = 0: `framing_err` pulse, byte dropped, assembler forced to WAIT_OP.

Assembler (WAIT_OP → WAIT_DATA → PENDING):
- WAIT_OP:
  - Byte with bit7 = 0 (short command): `opdata` = 0, go to PENDING.
  - Byte with bit7 = 1 (long command): latch opcode, clear the data counter, go to WAIT_DATA.
- WAIT_DATA: byte *n* (n = 0..3) goes to `opdata[8n+7:8n]`. After the 4th byte, go to PENDING.
- Timeout (WAIT_DATA only): counts ticks since the last byte. On reaching `TIMEOUT_BITS*OVERSAMPLE` ticks: `timeout` pulse, command discarded, go to WAIT_OP.
- PENDING:
  - `hold` = 0: drive `cmd`, `execute` and the matching query strobe; go to WAIT_OP.
  - `hold` = 1: wait in PENDING.
  - A byte arriving while in PENDING is dropped with an `overrun` pulse. The pending command is kept.

## Timing
Latencies:
- `byte_valid` occurs 1 cycle after the stop-bit sample.
- Short command: `execute` 2 cycles after the stop sample when `hold` = 0.
- Long command: `execute` 2 cycles after the 4th data byte's stop sample.
- `execute` is asserted 1 cycle after `hold` falls while in PENDING.

Simultaneous events:
- `extReset` beats everything.
- `byte_valid` and `baud_div_load` in the same cycle: the byte is delivered, then the divisor loads.
- `byte_valid` and timeout expiry in the same cycle: the byte wins and the counter clears.
- Delivery in the same cycle a new byte is validated: the new byte is treated as WAIT_OP input and gives no `overrun`.

Other rules:
- Five 0x00 bytes produce five separate `execute` + `query_reset` pulses.
- Opcodes other than 0x00, 0x02, 0x04 and 0x06 raise `execute` only.

## Structure
- `serial_pkg`:
  - opcode constants `OP_RESET` = 0x00, `OP_ID` = 0x02, `OP_METADATA` = 0x04, `OP_DATAIN` = 0x06;
  - byte-FSM and assembler state enums;
  - the `DEFAULT_DIV` function.
- One sub-module, `serial_rx_byte`: synchroniser, tick generator and byte FSM, with output `{byte_valid, byte_data, framing_err}`.
- The assembler lives in `serial_cmd_rx`.

## Test plan
- Short command, default rate: send 0x02 → one `execute` with `cmd` = 0x00000000_02 and a coincident `query_id`; no other strobe.
- Long command: send 0xC0, 0x11, 0x22, 0x33, 0x44 → `cmd` = 0x44332211_C0, single `execute`.
- Hold and overrun: hold = 1, send 0x04 then 0x06 → one `overrun`; release hold → single `execute` with `query_metadata`, `cmd` = 0x04.
- Timeout, with `TIMEOUT_BITS` = 32: send 0x81, 0xAA, then idle 40 bit-times → `timeout` pulse, no `execute`; a following 0x00 gives `execute` + `query_reset`.
- Framing error: byte 0x55 with stop bit = 0 → `framing_err`, no `execute`; the next valid 0x02 executes normally.
- Rate change: load `baud_div` = 3 mid-byte, then send 0xC1 + 4 bytes at FREQ/64 baud → correct `cmd`; the interrupted byte is lost silently.

Source files
------------

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the SUMP serial command front-end:
//   - SUMP opcode constants that have dedicated query strobes
//   - byte-receiver and command-assembler state encodings
//   - DEFAULT_DIV: power-on baud divisor (clocks per tick, minus 1)
// ---------------------------------------------------------------------------
package serial_pkg;

  localparam logic [7:0] OP_RESET    = 8'h00;
  localparam logic [7:0] OP_ID       = 8'h02;
  localparam logic [7:0] OP_METADATA = 8'h04;
  localparam logic [7:0] OP_DATAIN   = 8'h06;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    ASM_WAIT_OP   = 2'd0,
    ASM_WAIT_DATA = 2'd1,
    ASM_PENDING   = 2'd2
  } asm_state_e;

  // Integer division is intentional: the divisor truncates toward a
  // slightly faster tick, matching the original receiver.
  function automatic int unsigned DEFAULT_DIV(input int unsigned freq,
                                               input int unsigned rate,
                                               input int unsigned oversample);
    return (freq / (rate * oversample)) - 32'd1;
  endfunction

endpackage

// File: rtl/serial_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// serial_cmd_rx_if
// Command delivery bundle between the serial command receiver and the core
// decoder / transmitter.
//   cmd            {opdata[31:0], opcode[7:0]}, valid with execute
//   execute        one-cycle command strobe
//   query_*        one-cycle strobes coincident with execute
//   hold           consumer back-pressure: high defers delivery
// master = command receiver, slave = consumer.
// ---------------------------------------------------------------------------
interface serial_cmd_rx_if;
  logic [39:0] cmd;
  logic        execute;
  logic        query_id;
  logic        query_metadata;
  logic        query_dataIn;
  logic        query_reset;
  logic        hold;

  modport master (
    output cmd, execute, query_id, query_metadata, query_dataIn, query_reset,
    input  hold
  );

  modport slave (
    input  cmd, execute, query_id, query_metadata, query_dataIn, query_reset,
    output hold
  );
endinterface

// File: rtl/serial_rx_byte.sv
// ---------------------------------------------------------------------------
// serial_rx_byte
// Oversampling UART byte receiver: 2-flop synchroniser, reloadable baud tick
// generator and START/DATA/STOP byte FSM (8N1, LSB first).
// Ports:
//   clock, extReset       clock and synchronous active-high reset
//   rx                    asynchronous serial input
//   baud_div/_load        new divisor (clocks per tick - 1) and load strobe
//   tick                  one-cycle oversampling tick
//   byte_valid/byte_data  one-cycle pulse with the received byte
//   framing_err           one-cycle pulse on a low stop bit
// ---------------------------------------------------------------------------
module serial_rx_byte
  import serial_pkg::*;
#(
  parameter int unsigned OVERSAMPLE      = 16,
  parameter int unsigned DIV_W           = 16,
  parameter int unsigned DEFAULT_DIV_VAL = 53
) (
  input  logic             clock,
  input  logic             extReset,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             baud_div_load,
  output logic             tick,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             framing_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] tick_cnt_r;
  logic             tick_s;

  rx_state_e        state_r;
  rx_state_e        state_nxt_s;
  logic [TW-1:0]    tcnt_r;
  logic [TW-1:0]    tcnt_nxt_s;
  logic [2:0]       bit_r;
  logic [2:0]       bit_nxt_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic             ferr_r;
  logic             ferr_nxt_s;

  // Two-flop synchroniser; idles high like the line.
  always_ff @(posedge clock) begin
    if (extReset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  assign tick_s = (tick_cnt_r == {DIV_W{1'b0}});

  // Divisor register and tick down-counter; a load restarts the count so the
  // first tick at the new rate comes right after the load.
  always_ff @(posedge clock) begin
    if (extReset) begin
      div_r      <= DIV_W'(DEFAULT_DIV_VAL);
      tick_cnt_r <= {DIV_W{1'b0}};
    end else if (baud_div_load) begin
      div_r      <= baud_div;
      tick_cnt_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= div_r;
    end else begin
      tick_cnt_r <= tick_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Byte FSM next-state: all sampling happens on ticks; a divisor load aborts
  // any partial byte without reporting an error.
  always_comb begin
    state_nxt_s = state_r;
    tcnt_nxt_s  = tcnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    valid_nxt_s = 1'b0;
    ferr_nxt_s  = 1'b0;
    if (baud_div_load) begin
      state_nxt_s = RX_IDLE;
      tcnt_nxt_s  = {TW{1'b0}};
      bit_nxt_s   = 3'd0;
    end else if (tick_s) begin
      case (state_r)
        RX_IDLE: begin
          if (!rx_sync_r) begin
            state_nxt_s = RX_START;
            tcnt_nxt_s  = {TW{1'b0}};
          end else begin
            state_nxt_s = RX_IDLE;
          end
        end
        RX_START: begin
          // Mid start bit: a line already back high was only a glitch.
          if (tcnt_r == HALF_LAST) begin
            tcnt_nxt_s = {TW{1'b0}};
            bit_nxt_s  = 3'd0;
            if (!rx_sync_r) begin
              state_nxt_s = RX_DATA;
            end else begin
              state_nxt_s = RX_IDLE;
            end
          end else begin
            tcnt_nxt_s = tcnt_r + TW'(1);
          end
        end
        RX_DATA: begin
          if (tcnt_r == FULL_LAST) begin
            tcnt_nxt_s  = {TW{1'b0}};
            shift_nxt_s = {rx_sync_r, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_nxt_s = RX_STOP;
            end else begin
              bit_nxt_s = bit_r + 3'd1;
            end
          end else begin
            tcnt_nxt_s = tcnt_r + TW'(1);
          end
        end
        RX_STOP: begin
          if (tcnt_r == FULL_LAST) begin
            tcnt_nxt_s  = {TW{1'b0}};
            state_nxt_s = RX_IDLE;
            if (rx_sync_r) begin
              valid_nxt_s = 1'b1;
            end else begin
              ferr_nxt_s = 1'b1;
            end
          end else begin
            tcnt_nxt_s = tcnt_r + TW'(1);
          end
        end
        default: begin
          state_nxt_s = RX_IDLE;
          tcnt_nxt_s  = {TW{1'b0}};
          bit_nxt_s   = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Byte FSM state and registered result pulses.
  always_ff @(posedge clock) begin
    if (extReset) begin
      state_r <= RX_IDLE;
      tcnt_r  <= {TW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      valid_r <= valid_nxt_s;
      ferr_r  <= ferr_nxt_s;
    end
  end

  assign tick        = tick_s;
  assign byte_valid  = valid_r;
  assign byte_data   = shift_r;
  assign framing_err = ferr_r;

endmodule

// File: rtl/serial_cmd_rx.sv
// ---------------------------------------------------------------------------
// serial_cmd_rx
// SUMP command front-end: receives host bytes and assembles them into 40-bit
// commands {opdata, opcode}. Short opcodes (bit7 = 0) are single bytes; long
// opcodes carry four data bytes, least significant first.
// Ports:
//   clock, extReset       clock and synchronous active-high reset
//   rx                    asynchronous serial input
//   baud_div/_load        runtime baud divisor reload
//   bus (master)          cmd/execute/query strobes out, hold in
//   framing_err           one-cycle pulse, byte with low stop bit
//   overrun               one-cycle pulse, byte dropped while a command waits
//   timeout               one-cycle pulse, long command abandoned mid-way
// ---------------------------------------------------------------------------
module serial_cmd_rx
  import serial_pkg::*;
#(
  parameter int unsigned FREQ         = 100000000,
  parameter int unsigned RATE         = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned TIMEOUT_BITS = 32,
  parameter int unsigned DIV_W        = 16
) (
  input  logic             clock,
  input  logic             extReset,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             baud_div_load,
  serial_cmd_rx_if.master  bus,
  output logic             framing_err,
  output logic             overrun,
  output logic             timeout
);

  localparam int unsigned DIV_DEFAULT = DEFAULT_DIV(FREQ, RATE, OVERSAMPLE);
  localparam bit          TO_EN       = (TIMEOUT_BITS != 32'd0);
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_BITS * OVERSAMPLE - 32'd1);

  logic        tick_s;
  logic        byte_valid_s;
  logic [7:0]  byte_data_s;
  logic        framing_err_s;

  asm_state_e  asm_r;
  asm_state_e  asm_pre_s;
  asm_state_e  asm_nxt_s;
  logic [7:0]  opcode_r;
  logic [7:0]  opcode_nxt_s;
  logic [31:0] opdata_r;
  logic [31:0] opdata_nxt_s;
  logic [1:0]  dcnt_r;
  logic [1:0]  dcnt_nxt_s;
  logic [31:0] to_cnt_r;
  logic [31:0] to_cnt_nxt_s;

  logic        deliver_s;
  logic [39:0] deliver_cmd_s;
  logic        overrun_nxt_s;
  logic        timeout_nxt_s;

  logic [39:0] cmd_r;
  logic        exec_r;
  logic        q_id_r;
  logic        q_meta_r;
  logic        q_din_r;
  logic        q_rst_r;
  logic        overrun_r;
  logic        timeout_r;

  serial_rx_byte #(
    .OVERSAMPLE      (OVERSAMPLE),
    .DIV_W           (DIV_W),
    .DEFAULT_DIV_VAL (DIV_DEFAULT)
  ) u_rx_byte (
    .clock         (clock),
    .extReset      (extReset),
    .rx            (rx),
    .baud_div      (baud_div),
    .baud_div_load (baud_div_load),
    .tick          (tick_s),
    .byte_valid    (byte_valid_s),
    .byte_data     (byte_data_s),
    .framing_err   (framing_err_s)
  );

  // Assembler next-state. A command that completes with hold low is handed
  // over straight away; PENDING is only occupied while hold is high, or for
  // a short byte that arrives in the very cycle a pending command leaves.
  always_comb begin
    asm_pre_s     = asm_r;
    opcode_nxt_s  = opcode_r;
    opdata_nxt_s  = opdata_r;
    dcnt_nxt_s    = dcnt_r;
    to_cnt_nxt_s  = to_cnt_r;
    deliver_s     = 1'b0;
    deliver_cmd_s = cmd_r;
    overrun_nxt_s = 1'b0;
    timeout_nxt_s = 1'b0;
    case (asm_r)
      ASM_WAIT_OP: begin
        if (byte_valid_s) begin
          opcode_nxt_s = byte_data_s;
          opdata_nxt_s = 32'h0000_0000;
          dcnt_nxt_s   = 2'd0;
          to_cnt_nxt_s = 32'd0;
          if (byte_data_s[7]) begin
            asm_pre_s = ASM_WAIT_DATA;
          end else if (!bus.hold) begin
            deliver_s     = 1'b1;
            deliver_cmd_s = {32'h0000_0000, byte_data_s};
            asm_pre_s     = ASM_WAIT_OP;
          end else begin
            asm_pre_s = ASM_PENDING;
          end
        end else begin
          asm_pre_s = ASM_WAIT_OP;
        end
      end
      ASM_WAIT_DATA: begin
        // A byte always beats a timeout expiring in the same cycle.
        if (byte_valid_s) begin
          to_cnt_nxt_s = 32'd0;
          case (dcnt_r)
            2'd0:    opdata_nxt_s[7:0]   = byte_data_s;
            2'd1:    opdata_nxt_s[15:8]  = byte_data_s;
            2'd2:    opdata_nxt_s[23:16] = byte_data_s;
            default: opdata_nxt_s[31:24] = byte_data_s;
          endcase
          if (dcnt_r == 2'd3) begin
            dcnt_nxt_s = 2'd0;
            if (!bus.hold) begin
              deliver_s     = 1'b1;
              deliver_cmd_s = {byte_data_s, opdata_r[23:0], opcode_r};
              asm_pre_s     = ASM_WAIT_OP;
            end else begin
              asm_pre_s = ASM_PENDING;
            end
          end else begin
            dcnt_nxt_s = dcnt_r + 2'd1;
          end
        end else if (TO_EN && tick_s) begin
          if (to_cnt_r == TO_LAST) begin
            timeout_nxt_s = 1'b1;
            to_cnt_nxt_s  = 32'd0;
            asm_pre_s     = ASM_WAIT_OP;
          end else begin
            to_cnt_nxt_s = to_cnt_r + 32'd1;
          end
        end else begin
          to_cnt_nxt_s = to_cnt_r;
        end
      end
      ASM_PENDING: begin
        if (!bus.hold) begin
          deliver_s     = 1'b1;
          deliver_cmd_s = {opdata_r, opcode_r};
          // A byte landing on the delivery cycle starts the next command; a
          // short one parks in PENDING so the two strobes stay separate.
          if (byte_valid_s) begin
            opcode_nxt_s = byte_data_s;
            opdata_nxt_s = 32'h0000_0000;
            dcnt_nxt_s   = 2'd0;
            to_cnt_nxt_s = 32'd0;
            if (byte_data_s[7]) begin
              asm_pre_s = ASM_WAIT_DATA;
            end else begin
              asm_pre_s = ASM_PENDING;
            end
          end else begin
            asm_pre_s = ASM_WAIT_OP;
          end
        end else begin
          overrun_nxt_s = byte_valid_s;
          asm_pre_s     = ASM_PENDING;
        end
      end
      default: begin
        asm_pre_s = ASM_WAIT_OP;
      end
    endcase
    asm_nxt_s = framing_err_s ? ASM_WAIT_OP : asm_pre_s;
  end

  // Assembler state and registered command outputs.
  always_ff @(posedge clock) begin
    if (extReset) begin
      asm_r     <= ASM_WAIT_OP;
      opcode_r  <= 8'h00;
      opdata_r  <= 32'h0000_0000;
      dcnt_r    <= 2'd0;
      to_cnt_r  <= 32'd0;
      cmd_r     <= 40'h00_0000_0000;
      exec_r    <= 1'b0;
      q_id_r    <= 1'b0;
      q_meta_r  <= 1'b0;
      q_din_r   <= 1'b0;
      q_rst_r   <= 1'b0;
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      asm_r     <= asm_nxt_s;
      opcode_r  <= opcode_nxt_s;
      opdata_r  <= opdata_nxt_s;
      dcnt_r    <= dcnt_nxt_s;
      to_cnt_r  <= to_cnt_nxt_s;
      cmd_r     <= deliver_cmd_s;
      exec_r    <= deliver_s;
      q_id_r    <= deliver_s && (deliver_cmd_s[7:0] == OP_ID);
      q_meta_r  <= deliver_s && (deliver_cmd_s[7:0] == OP_METADATA);
      q_din_r   <= deliver_s && (deliver_cmd_s[7:0] == OP_DATAIN);
      q_rst_r   <= deliver_s && (deliver_cmd_s[7:0] == OP_RESET);
      overrun_r <= overrun_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign bus.cmd            = cmd_r;
  assign bus.execute        = exec_r;
  assign bus.query_id       = q_id_r;
  assign bus.query_metadata = q_meta_r;
  assign bus.query_dataIn   = q_din_r;
  assign bus.query_reset    = q_rst_r;
  assign framing_err        = framing_err_s;
  assign overrun            = overrun_r;
  assign timeout            = timeout_r;

endmodule

// File: tb/tb_serial_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_cmd_rx
// Directed bench for serial_cmd_rx. Clock 100 MHz, default rate chosen so
// the default divisor is 7 (128 clocks per bit); the rate-change step loads
// divisor 3 (64 clocks per bit). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_serial_cmd_rx;

  localparam int unsigned FREQ         = 100000000;
  localparam int unsigned RATE         = 781250;
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned TIMEOUT_BITS = 32;
  localparam int unsigned DIV_W        = 16;
  localparam int BIT_DEF  = 128;
  localparam int BIT_FAST = 64;

  logic             clock = 1'b0;
  logic             extReset;
  logic             rx;
  logic [DIV_W-1:0] baud_div;
  logic             baud_div_load;
  logic             framing_err;
  logic             overrun;
  logic             timeout;

  serial_cmd_rx_if bus ();

  serial_cmd_rx #(
    .FREQ         (FREQ),
    .RATE         (RATE),
    .OVERSAMPLE   (OVERSAMPLE),
    .TIMEOUT_BITS (TIMEOUT_BITS),
    .DIV_W        (DIV_W)
  ) dut (
    .clock         (clock),
    .extReset      (extReset),
    .rx            (rx),
    .baud_div      (baud_div),
    .baud_div_load (baud_div_load),
    .bus           (bus),
    .framing_err   (framing_err),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  int exec_cnt, qid_cnt, qmeta_cnt, qdin_cnt, qrst_cnt, stray_cnt;
  int ferr_cnt, ovr_cnt, to_cnt;
  logic [39:0] last_cmd = 40'h0;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (bus.execute === 1'b1) begin
      exec_cnt = exec_cnt + 1;
      last_cmd = bus.cmd;
      if (bus.query_id === 1'b1)       qid_cnt   = qid_cnt + 1;
      if (bus.query_metadata === 1'b1) qmeta_cnt = qmeta_cnt + 1;
      if (bus.query_dataIn === 1'b1)   qdin_cnt  = qdin_cnt + 1;
      if (bus.query_reset === 1'b1)    qrst_cnt  = qrst_cnt + 1;
    end else if ((bus.query_id | bus.query_metadata | bus.query_dataIn | bus.query_reset) === 1'b1) begin
      stray_cnt = stray_cnt + 1;
    end
    if (framing_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (overrun === 1'b1)     ovr_cnt  = ovr_cnt + 1;
    if (timeout === 1'b1)     to_cnt   = to_cnt + 1;
  end

  task automatic clear_counts();
    exec_cnt = 0; qid_cnt = 0; qmeta_cnt = 0; qdin_cnt = 0; qrst_cnt = 0;
    stray_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; to_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // 8N1 frame followed by one idle bit; starts just after a rising edge.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit, input int bit_clk);
    #1 rx = 1'b0;
    repeat (bit_clk) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1 rx = data[i];
      repeat (bit_clk) @(posedge clock);
    end
    #1 rx = stop_bit;
    repeat (bit_clk) @(posedge clock);
    #1 rx = 1'b1;
    repeat (bit_clk) @(posedge clock);
  endtask

  initial begin
    clear_counts();
    extReset      = 1'b1;
    rx            = 1'b1;
    baud_div      = 16'd0;
    baud_div_load = 1'b0;
    bus.hold      = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("rst_execute", {63'd0, bus.execute}, 64'd0);
    check("rst_cmd", {24'd0, bus.cmd}, 64'd0);
    check("rst_strobes", {60'd0, bus.query_id, bus.query_metadata, bus.query_dataIn, bus.query_reset}, 64'd0);
    check("rst_errs", {61'd0, framing_err, overrun, timeout}, 64'd0);
    @(posedge clock);
    #1 extReset = 1'b0;
    repeat (20) @(posedge clock);
    clear_counts();

    // Short command 0x02
    send_byte(8'h02, 1'b1, BIT_DEF);
    check("short_exec", exec_cnt, 64'd1);
    check("short_cmd", {24'd0, last_cmd}, 64'h00_0000_0002);
    check("short_qid", qid_cnt, 64'd1);
    check("short_other_q", qmeta_cnt + qdin_cnt + qrst_cnt + stray_cnt, 64'd0);

    // Long command 0xC0 + 11 22 33 44
    clear_counts();
    send_byte(8'hC0, 1'b1, BIT_DEF);
    send_byte(8'h11, 1'b1, BIT_DEF);
    send_byte(8'h22, 1'b1, BIT_DEF);
    send_byte(8'h33, 1'b1, BIT_DEF);
    check("long_no_early_exec", exec_cnt, 64'd0);
    send_byte(8'h44, 1'b1, BIT_DEF);
    check("long_exec", exec_cnt, 64'd1);
    check("long_cmd", {24'd0, last_cmd}, 64'h44_3322_11C0);
    check("long_no_q", qid_cnt + qmeta_cnt + qdin_cnt + qrst_cnt + stray_cnt, 64'd0);

    // Hold and overrun
    clear_counts();
    bus.hold = 1'b1;
    send_byte(8'h04, 1'b1, BIT_DEF);
    send_byte(8'h06, 1'b1, BIT_DEF);
    check("hold_overrun", ovr_cnt, 64'd1);
    check("hold_no_exec", exec_cnt, 64'd0);
    @(posedge clock);
    #1 bus.hold = 1'b0;
    @(negedge clock);
    check("hold_release_lat0", {63'd0, bus.execute}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("hold_release_exec", {63'd0, bus.execute}, 64'd1);
    check("hold_release_cmd", {24'd0, bus.cmd}, 64'h00_0000_0004);
    check("hold_release_qmeta", {63'd0, bus.query_metadata}, 64'd1);
    repeat (10) @(posedge clock);
    check("hold_single_exec", exec_cnt, 64'd1);
    check("hold_no_qdin", qdin_cnt, 64'd0);

    // Inter-byte timeout
    clear_counts();
    send_byte(8'h81, 1'b1, BIT_DEF);
    send_byte(8'hAA, 1'b1, BIT_DEF);
    repeat (40 * BIT_DEF) @(posedge clock);
    check("to_pulse", to_cnt, 64'd1);
    check("to_no_exec", exec_cnt, 64'd0);
    send_byte(8'h00, 1'b1, BIT_DEF);
    check("to_next_exec", exec_cnt, 64'd1);
    check("to_next_qrst", qrst_cnt, 64'd1);
    check("to_next_cmd", {24'd0, last_cmd}, 64'h00_0000_0000);

    // Framing error
    clear_counts();
    send_byte(8'h55, 1'b0, BIT_DEF);
    check("fe_pulse", ferr_cnt, 64'd1);
    check("fe_no_exec", exec_cnt, 64'd0);
    send_byte(8'h02, 1'b1, BIT_DEF);
    check("fe_next_exec", exec_cnt, 64'd1);
    check("fe_next_cmd", {24'd0, last_cmd}, 64'h00_0000_0002);
    check("fe_next_qid", qid_cnt, 64'd1);

    // Rate change in the middle of a byte
    clear_counts();
    #1 rx = 1'b0;
    repeat (BIT_DEF) @(posedge clock);
    #1 rx = 1'b1;
    repeat (BIT_DEF / 2) @(posedge clock);
    #1 baud_div = 16'd3; baud_div_load = 1'b1;
    @(posedge clock);
    #1 baud_div_load = 1'b0; baud_div = 16'd0;
    repeat (4 * BIT_FAST) @(posedge clock);
    send_byte(8'hC1, 1'b1, BIT_FAST);
    send_byte(8'h01, 1'b1, BIT_FAST);
    send_byte(8'h02, 1'b1, BIT_FAST);
    send_byte(8'h03, 1'b1, BIT_FAST);
    send_byte(8'h04, 1'b1, BIT_FAST);
    check("rate_exec", exec_cnt, 64'd1);
    check("rate_cmd", {24'd0, last_cmd}, 64'h04_0302_01C1);
    check("rate_silent", ferr_cnt + ovr_cnt + to_cnt, 64'd0);

    // Five reset opcodes give five separate strobes
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h00, 1'b1, BIT_FAST);
    end
    check("reset5_exec", exec_cnt, 64'd5);
    check("reset5_qrst", qrst_cnt, 64'd5);

    // Unrecognised short opcode: execute only
    clear_counts();
    send_byte(8'h10, 1'b1, BIT_FAST);
    check("plain_exec", exec_cnt, 64'd1);
    check("plain_cmd", {24'd0, last_cmd}, 64'h00_0000_0010);
    check("plain_no_q", qid_cnt + qmeta_cnt + qdin_cnt + qrst_cnt + stray_cnt, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
